// File: rtl/keypad_tx.sv
// Keypad-side transmitter: serialises a two-digit item code as two timed
// KEY_PRESS strobes with ITEM_CODE held stable around each strobe.
module keypad_tx #(
  parameter int PULSE_LEN  = 1,
  parameter int GAP_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       send_i,
  input  logic [3:0] digit_hi_i,
  input  logic [3:0] digit_lo_i,
  input  logic       abort_i,
  output logic [3:0] item_code_o,
  output logic       key_press_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       bad_digit_o,
  output logic       aborted_o
);

  localparam int MAXD = (PULSE_LEN > GAP_CYCLES) ? PULSE_LEN : GAP_CYCLES;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  typedef enum logic [2:0] {
    IDLE, HI_SETUP, HI_PULSE, GAP, LO_SETUP, LO_PULSE, FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    hi_q, hi_d, lo_q, lo_d;
  logic          bad_pend_q, bad_pend_d;
  logic [3:0]    item_q, item_d;
  logic          kp_q, kp_d, busy_q, busy_d, done_q, done_d;
  logic          bad_q, bad_d, abrt_q, abrt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      bad_pend_q <= 1'b0;
      item_q     <= '0;
      kp_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      abrt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      bad_pend_q <= bad_pend_d;
      item_q     <= item_d;
      kp_q       <= kp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      abrt_q     <= abrt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    bad_pend_d = 1'b0;
    item_d     = '0;
    kp_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bad_d      = bad_pend_q;
    abrt_d     = 1'b0;

    // Outputs are a registered decode of the state being left, so every
    // output trails the state register by one cycle.
    unique case (state_q)
      HI_SETUP: begin item_d = hi_q; busy_d = 1'b1; end
      HI_PULSE: begin item_d = hi_q; busy_d = 1'b1; kp_d = 1'b1; end
      GAP:      begin item_d = hi_q; busy_d = 1'b1; end
      LO_SETUP: begin item_d = lo_q; busy_d = 1'b1; end
      LO_PULSE: begin item_d = lo_q; busy_d = 1'b1; kp_d = 1'b1; end
      FINISH:   done_d = 1'b1;
      default:  ;
    endcase

    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      item_d  = '0;
      kp_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      abrt_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (send_i) begin
          if (digit_hi_i > 4'd9 || digit_lo_i > 4'd9) begin
            bad_pend_d = 1'b1;
          end else begin
            hi_d    = digit_hi_i;
            lo_d    = digit_lo_i;
            cnt_d   = '0;
            state_d = HI_SETUP;
          end
        end
        HI_SETUP: begin
          state_d = HI_PULSE;
          cnt_d   = CW'(PULSE_LEN - 1);
        end
        HI_PULSE: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = LO_SETUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        LO_SETUP: begin
          state_d = LO_PULSE;
          cnt_d   = CW'(PULSE_LEN - 1);
        end
        LO_PULSE: begin
          if (cnt_q == '0) begin
            state_d = FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        FINISH: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign item_code_o = item_q;
  assign key_press_o = kp_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bad_digit_o = bad_q;
  assign aborted_o   = abrt_q;

endmodule
